// File: rtl/jt10_adpcmb_seq_pkg.sv
// jt10_adpcmb_seq_pkg
//   Shared definitions for the ADPCM-B playback sequencer:
//   FSM state encodings, delta-N accumulator width, default chon hold
//   length and the byte-buffer entry type.
package jt10_adpcmb_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int ACC_W         = 16;
  localparam int CHON_HOLD_DEF = 8;

  // One byte-buffer slot: valid, last-byte-of-sample marker, payload.
  typedef struct packed {
    logic       v;
    logic       last;
    logic [7:0] dat;
  } buf_t;

endpackage

// File: rtl/jt10_adpcmb_seq_dn.sv
// jt10_adpcmb_dn
//   Delta-N phase accumulator. Each enabled cen cycle adds delta_n to a
//   16-bit accumulator; the carry out of bit 15 is registered and is
//   high for exactly one cen cycle per overflow (one nibble request).
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   cen          - clock enable
//   en           - accumulate this cycle
//   clr          - clear accumulator and carry (takes priority over en)
//   delta_n      - rate word
//   carry        - registered overflow strobe
module jt10_adpcmb_dn
  import jt10_adpcmb_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             en,
  input  logic             clr,
  input  logic [ACC_W-1:0] delta_n,
  output logic             carry
);

  logic [ACC_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (cen) begin
      if (clr) begin
        acc   <= '0;
        carry <= 1'b0;
      end else if (en) begin
        {carry, acc} <= {1'b0, acc} + {1'b0, delta_n};
      end else begin
        carry <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jt10_adpcmb_seq.sv
// jt10_adpcmb_seq
//   ADPCM-B playback sequencer. Fetches sample bytes from ROM between
//   {addr_start,00} and {addr_end,FF}, double-buffers them, splits them
//   into nibbles (high first) and strobes them into the decoder at the
//   delta-N rate. Raises a sticky end flag when a non-repeating sample
//   finishes and keeps chon high CHON_HOLD cen cycles afterwards so the
//   decoder pipeline drains.
// Ports:
//   clk, rst, cen                 - clock, sync active-high reset, enable
//   start, repeat_en              - play level, loop enable
//   addr_start, addr_end, delta_n - channel registers
//   flag_clr                      - clears flag_end
//   rom_addr, rom_cs              - fetch request (address stable while cs)
//   rom_data, rom_ok              - fetch response, held until cs falls
//   data, adv, chon               - decoder interface
//   flag_end                      - sticky end-of-sample flag
//
// state | meaning
// IDLE  | channel off, no fetches
// RUN   | fetching and emitting nibbles
// HOLD  | sample ended, chon held while the decoder drains
module jt10_adpcmb_seq
  import jt10_adpcmb_seq_pkg::*;
#(
  parameter int AW        = 24,
  parameter int CHON_HOLD = CHON_HOLD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          start,
  input  logic          repeat_en,
  input  logic [15:0]   addr_start,
  input  logic [15:0]   addr_end,
  input  logic [15:0]   delta_n,
  input  logic          flag_clr,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [3:0]    data,
  output logic          adv,
  output logic          chon,
  output logic          flag_end
);

  localparam int HW = ($clog2(CHON_HOLD) < 1) ? 1 : $clog2(CHON_HOLD);

  state_t        state;
  logic          start_l;
  logic [AW-1:0] ptr;
  logic          stopped;
  buf_t          cur, nxt;
  buf_t          cur_n, nxt_n;
  logic          half;
  logic          pending;
  logic [HW-1:0] hold_cnt;
  logic          carry;

  logic          start_rise;
  logic          run;
  logic          got;
  logic          fire;
  logic          consume;
  logic          end_hit;
  logic          ptr_last;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;

  assign rom_addr   = ptr;
  assign first_addr = AW'({addr_start, 8'h00});
  assign last_addr  = AW'({addr_end, 8'hFF});
  assign ptr_last   = (ptr == last_addr);

  assign start_rise = start & ~start_l;
  // RUN work only happens when neither abort nor restart overrides it
  assign run        = (state == ST_RUN) & start & ~start_rise;
  assign got        = run & rom_cs & rom_ok;
  assign fire       = run & (carry | pending) & cur.v;
  assign consume    = fire & half;
  assign end_hit    = consume & cur.last & ~repeat_en;

  jt10_adpcmb_dn u_dn (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .en      (state == ST_RUN),
    .clr     (start_rise),
    .delta_n (delta_n),
    .carry   (carry)
  );

  // Buffer update: first retire cur if its low nibble goes out, then
  // place the incoming byte in the first free slot. A fetch is only
  // issued with nxt empty, so an arriving byte always finds room.
  always_comb begin
    cur_n = cur;
    nxt_n = nxt;
    if (consume) begin
      cur_n = nxt;
      nxt_n = '0;
    end
    if (got) begin
      if (!cur_n.v) cur_n = '{v: 1'b1, last: ptr_last, dat: rom_data};
      else          nxt_n = '{v: 1'b1, last: ptr_last, dat: rom_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      start_l  <= 1'b0;
      ptr      <= '0;
      stopped  <= 1'b0;
      cur      <= '0;
      nxt      <= '0;
      half     <= 1'b0;
      pending  <= 1'b0;
      hold_cnt <= '0;
      rom_cs   <= 1'b0;
      data     <= 4'd0;
      adv      <= 1'b0;
      chon     <= 1'b0;
      flag_end <= 1'b0;
    end else if (cen) begin
      start_l <= start;
      adv     <= 1'b0;

      if (!start) begin
        state   <= ST_IDLE;
        rom_cs  <= 1'b0;
        chon    <= 1'b0;
        pending <= 1'b0;
      end else if (start_rise) begin
        state   <= ST_RUN;
        ptr     <= first_addr;
        rom_cs  <= 1'b1;
        chon    <= 1'b1;
        cur     <= '0;
        nxt     <= '0;
        half    <= 1'b0;
        pending <= 1'b0;
        stopped <= 1'b0;
      end else begin
        case (state)
          ST_RUN: begin
            cur <= cur_n;
            nxt <= nxt_n;

            if (got) begin
              rom_cs <= 1'b0;
              if (ptr_last) begin
                if (repeat_en) ptr     <= first_addr;
                else           stopped <= 1'b1;
              end else begin
                ptr <= ptr + AW'(1);
              end
            end else if (!rom_cs && !nxt.v && !stopped) begin
              rom_cs <= 1'b1;
            end

            if (fire) begin
              adv     <= 1'b1;
              data    <= half ? cur.dat[3:0] : cur.dat[7:4];
              half    <= ~half;
              pending <= 1'b0;
            end else if (carry && !cur.v) begin
              // fetch latency: remember one request, later ones drop
              pending <= 1'b1;
            end

            if (end_hit) begin
              state    <= ST_HOLD;
              rom_cs   <= 1'b0;
              hold_cnt <= HW'(CHON_HOLD - 1);
            end
          end

          ST_HOLD: begin
            rom_cs <= 1'b0;
            if (hold_cnt == '0) begin
              state <= ST_IDLE;
              chon  <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - HW'(1);
            end
          end

          default: begin
            rom_cs <= 1'b0;
          end
        endcase
      end

      if (end_hit)       flag_end <= 1'b1;
      else if (flag_clr) flag_end <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jt10_adpcmb_seq.sv
module tb_jt10_adpcmb_seq;

  logic        clk = 1'b0;
  logic        rst, cen, start, repeat_en, flag_clr;
  logic [15:0] addr_start, addr_end, delta_n;
  logic [23:0] rom_addr;
  logic        rom_cs, rom_ok;
  logic [7:0]  rom_data;
  logic [3:0]  data;
  logic        adv, chon, flag_end;

  always #5 clk = ~clk;

  jt10_adpcmb_seq dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .repeat_en(repeat_en),
    .addr_start(addr_start), .addr_end(addr_end), .delta_n(delta_n),
    .flag_clr(flag_clr), .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_data(rom_data), .rom_ok(rom_ok), .data(data), .adv(adv),
    .chon(chon), .flag_end(flag_end)
  );

  // ROM model: byte = low address byte, answers lat cen cycles after cs
  int lat = 0;
  int wait_cnt = 0;
  always @(posedge clk) begin
    if (!rom_cs) wait_cnt <= 0;
    else if (cen && wait_cnt < lat) wait_cnt <= wait_cnt + 1;
  end
  assign rom_ok   = rom_cs && (wait_cnt >= lat);
  assign rom_data = rom_addr[7:0];

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] nib_exp(int k);
    logic [7:0] b;
    b = 8'((k >> 1) & 255);
    return (k & 1) ? b[3:0] : b[7:4];
  endfunction

  // monitor state, owned by the main initial block only
  int          cyc, nib_cnt, seq_err, gap_err, last_adv, exp_gap;
  int          fetch_cnt, addr_err, wrap_seen;
  logic [23:0] prev_addr, sa_full, ea_full;

  task automatic mon_clear();
    nib_cnt = 0; seq_err = 0; gap_err = 0; last_adv = 0;
    fetch_cnt = 0; addr_err = 0; wrap_seen = 0; prev_addr = '0;
    sa_full = {addr_start, 8'h00};
    ea_full = {addr_end, 8'hFF};
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (adv) begin
      if (data !== nib_exp(nib_cnt)) seq_err++;
      if (nib_cnt > 0 && exp_gap != 0 && (cyc - last_adv) != exp_gap) gap_err++;
      last_adv = cyc;
      nib_cnt++;
    end
    if (rom_cs && rom_ok) begin
      if (fetch_cnt == 0) begin
        if (rom_addr !== sa_full) addr_err++;
      end else if (prev_addr == ea_full && rom_addr == sa_full) begin
        wrap_seen = 1;
      end else if (rom_addr !== prev_addr + 24'd1) begin
        addr_err++;
      end
      prev_addr = rom_addr;
      fetch_cnt++;
    end
  endtask

  typedef struct {
    logic [15:0] sa, ea, dn;
    logic        rep;
    int          lat;
    int          nibs;
    logic        flag;
    int          gap;
  } vec_t;
  vec_t vecs[4];

  task automatic setup(logic [15:0] sa, logic [15:0] ea, logic [15:0] dn,
                       logic rep, int l, int gap);
    start = 1'b0;
    flag_clr = 1'b1;
    repeat (3) step();
    flag_clr = 1'b0;
    addr_start = sa; addr_end = ea; delta_n = dn; repeat_en = rep;
    lat = l; exp_gap = gap;
    mon_clear();
  endtask

  initial begin
    int d;
    rst = 1'b1; cen = 1'b1; start = 1'b0; repeat_en = 1'b0; flag_clr = 1'b0;
    addr_start = 16'h0; addr_end = 16'h0; delta_n = 16'h0;
    cyc = 0; exp_gap = 0;
    mon_clear();
    repeat (3) step();
    chk("rst_rom_cs", rom_cs, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_adv", adv, 0);
    chk("rst_chon", chon, 0);
    chk("rst_flag", flag_end, 0);
    chk("rst_data", data, 0);
    rst = 1'b0;
    step();

    vecs[0] = '{sa: 16'h0012, ea: 16'h0012, dn: 16'h8000, rep: 1'b0, lat: 0,  nibs: 512,  flag: 1'b1, gap: 2};
    vecs[1] = '{sa: 16'h0012, ea: 16'h0012, dn: 16'h8000, rep: 1'b1, lat: 0,  nibs: 600,  flag: 1'b0, gap: 2};
    vecs[2] = '{sa: 16'h0012, ea: 16'h0012, dn: 16'hFFFF, rep: 1'b0, lat: 20, nibs: 512,  flag: 1'b1, gap: 0};
    vecs[3] = '{sa: 16'h0034, ea: 16'h0035, dn: 16'h4000, rep: 1'b0, lat: 3,  nibs: 1024, flag: 1'b1, gap: 4};

    for (int i = 0; i < 4; i++) begin
      setup(vecs[i].sa, vecs[i].ea, vecs[i].dn, vecs[i].rep, vecs[i].lat, vecs[i].gap);
      start = 1'b1;
      if (!vecs[i].rep) begin
        for (int t = 0; t < 20000 && !flag_end; t++) step();
        chk($sformatf("v%0d_flag_wait", i), flag_end, 1);
        d = 0;
        while (d < 20 && chon) begin step(); d++; end
        chk($sformatf("v%0d_chon_hold", i), d, 8);
        chk($sformatf("v%0d_fetches", i), fetch_cnt, vecs[i].nibs / 2);
        chk($sformatf("v%0d_cs_idle", i), rom_cs, 0);
      end else begin
        for (int t = 0; t < 20000 && nib_cnt < vecs[i].nibs; t++) step();
        chk($sformatf("v%0d_wrap", i), wrap_seen, 1);
      end
      chk($sformatf("v%0d_nibbles", i), nib_cnt, vecs[i].nibs);
      chk($sformatf("v%0d_seq_err", i), seq_err, 0);
      chk($sformatf("v%0d_gap_err", i), gap_err, 0);
      chk($sformatf("v%0d_addr_err", i), addr_err, 0);
      chk($sformatf("v%0d_flag_end", i), flag_end, vecs[i].flag);
    end

    // abort mid-fetch, then restart from addr_start
    setup(16'h0056, 16'h0056, 16'h8000, 1'b0, 20, 0);
    start = 1'b1;
    step();
    chk("abort_cs_first", rom_cs, 1);
    chk("abort_addr_first", rom_addr, 24'h005600);
    repeat (5) step();
    start = 1'b0;
    step();
    chk("abort_cs_drop", rom_cs, 0);
    chk("abort_chon_drop", chon, 0);
    start = 1'b1;
    step();
    chk("abort_cs_again", rom_cs, 1);
    chk("abort_addr_again", rom_addr, 24'h005600);

    // flag_clr coincident with end: set wins; a later clear works
    setup(16'h0012, 16'h0012, 16'h8000, 1'b0, 0, 2);
    start = 1'b1;
    for (int t = 0; t < 3000 && nib_cnt < 511; t++) step();
    chk("clr_reach_511", nib_cnt, 511);
    step();
    flag_clr = 1'b1;
    step();
    chk("clr_end_adv", adv, 1);
    chk("clr_set_wins", flag_end, 1);
    flag_clr = 1'b0;
    step();
    chk("clr_sticky", flag_end, 1);
    flag_clr = 1'b1;
    step();
    chk("clr_cleared", flag_end, 0);
    flag_clr = 1'b0;

    // reset during RUN with cen low
    setup(16'h0012, 16'h0012, 16'h8000, 1'b0, 0, 2);
    start = 1'b1;
    repeat (40) step();
    chk("run_chon", chon, 1);
    cen = 1'b0;
    rst = 1'b1;
    step();
    chk("rrst_rom_cs", rom_cs, 0);
    chk("rrst_rom_addr", rom_addr, 0);
    chk("rrst_adv", adv, 0);
    chk("rrst_chon", chon, 0);
    chk("rrst_data", data, 0);
    chk("rrst_flag", flag_end, 0);
    rst = 1'b0;
    cen = 1'b1;
    start = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
